roce_rx_header_consumer: RTL
============================

// Module: roce_rx_header_consumer
// PURPOSE
//  Receive-side counterpart of the RoCEv2 TX header producer. Consumes parsed BTH/RETH headers and the RoCE payload
//  stream, checks PSN and RDMA-WRITE opcode sequencing, tracks target address/remaining length, forwards the payload
//  tagged with its write address, and emits one ACK/NAK descriptor per packet with ack_req set or on error.
// PARAMETERS
//  DATA_WIDTH  64  payload width, bits; KEEP_WIDTH = DATA_WIDTH/8
// PORTS
//  clk                   in   1           clock
//  resetn                in   1           synchronous, active-low reset
//  s_roce_bth_valid/ready in/out 1        BTH header handshake
//  s_roce_bth_op_code    in   8           opcode
//  s_roce_bth_psn        in   24          packet sequence number
//  s_roce_bth_dest_qp    in   24          destination QP
//  s_roce_bth_ack_req    in   1           ACK requested
//  s_roce_reth_valid/ready in/out 1       RETH handshake (only for FIRST/ONLY)
//  s_roce_reth_v_addr    in   64          virtual address;  s_roce_reth_length in 32 DMA length, bytes
//  s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/out  DATA_WIDTH/KEEP_WIDTH/1/1/1/1  RoCE payload in
//  m_axis_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  payload out, same widths
//  m_axis_tuser          out  1           on tlast beat: 1 = packet bad (length overrun/short or s_axis_tuser seen)
//  m_axis_addr           out  64          write address of current beat's byte 0
//  m_ack_valid/ready     out/in 1         ACK descriptor handshake
//  m_ack_psn             out  24          PSN acknowledged
//  m_ack_syndrome        out  8           0x00 ACK, 0x60 NAK PSN seq err, 0x61 NAK invalid request
//  cfg_local_qp          in   24          local QP number (used only with ROCE_RX_QP_FILTER_EN)
//  stat_drop_count       out  32          packets dropped, saturating
// BEHAVIOUR
//  Reset: all ready/valid outs 0, epsn 0, psn_sync 0, in_msg 0, addr 0, remaining 0, stat_drop_count 0, state IDLE.
//  Opcodes: 0x06 FIRST, 0x07 MIDDLE, 0x08 LAST, 0x09 LAST_IMM, 0x0A ONLY, 0x0B ONLY_IMM; others -> invalid request.
//  FSM: IDLE -> (bth accepted) CHECK -> [FIRST/ONLY] RETH -> PASS | DROP -> ACK (if needed) -> IDLE.
//  IDLE: s_roce_bth_ready=1; header latched on handshake; ready drops for rest of packet.
//  CHECK (1 cycle): psn_sync=0 -> epsn := psn, psn_sync := 1. psn!=epsn -> NAK 0x60, DROP, epsn unchanged.
//   FIRST/ONLY with in_msg=1, or MIDDLE/LAST with in_msg=0, or unknown opcode -> NAK 0x61, DROP, in_msg := 0.
//  RETH: s_roce_reth_ready=1 until handshake; addr := v_addr, remaining := length; in_msg := 1 for FIRST.
//  PASS: s_axis_tready = m_axis_tready (flow-through, zero added latency per beat); m_axis_addr = addr;
//   addr += popcount(tkeep) and remaining -= popcount(tkeep) per accepted beat (64-bit wrap, 32-bit clamp at 0).
//   popcount > remaining on any beat, or remaining != 0 at tlast of LAST/ONLY -> m_axis_tuser=1 on tlast beat.
//   On tlast: epsn := epsn+1 (24-bit wrap 0xFFFFFF -> 0); LAST/ONLY clear in_msg.
//  DROP: s_axis_tready=1, nothing forwarded, until tlast; stat_drop_count += 1 (saturates at 0xFFFFFFFF).
//  ACK: entered if ack_req or NAK; m_ack_valid held until m_ack_ready; ACK psn = packet psn; NAK psn = epsn.
//   No new BTH accepted while ACK pending (back-pressure, never lose descriptor).
//  Payload with no matching header is never accepted (tready=0 outside PASS/DROP).
//  s_axis_tuser=1 on any beat in PASS -> packet marked bad, epsn still advances.
//  Reset mid-packet: all state cleared next edge; partial payload not completed; psn_sync := 0.
// CONFIGURATION
//  ROCE_RX_QP_FILTER_EN defined: in CHECK, dest_qp != cfg_local_qp -> silent DROP (no ACK/NAK, epsn and in_msg
//   untouched, stat_drop_count += 1); checked before PSN. Undefined: dest_qp ignored, cfg_local_qp unused.
// TESTING
//  ONLY psn=5, v_addr=0x1000, len=64, 8 full beats, ack_req=1 -> 8 beats out, addrs 0x1000..0x1038, ACK psn=5 syn=0x00.
//  FIRST(len=3200,psn=0)+MIDDLE+LAST, 1024/1024/1152 B -> LAST addr_0=v_addr+2048, tuser=0, epsn=3, in_msg=0.
//  After sync epsn=10, packet psn=12 -> payload dropped, NAK psn=10 syn=0x60, stat_drop_count=1.
//  MIDDLE with in_msg=0 -> DROP, NAK syn=0x61; epsn wrap: psn 0xFFFFFF accepted -> epsn=0.
//  ONLY len=60, 8 full beats -> m_axis_tuser=1 on tlast; m_ack_ready=0 for 20 cycles -> next BTH ready stays 0.
//  ROCE_RX_QP_FILTER_EN, cfg_local_qp=0x11, dest_qp=0x12 -> silent drop, no m_ack_valid, count +1.

Source files
------------

// File: rtl/roce_rx_header_consumer_if.sv
// RoCEv2 RX bundle: BTH/RETH headers, payload in/out, ACK/NAK descriptor.
// slave = consumer side, master = header/payload source and sink side.
interface roce_rx_header_consumer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
);
  logic                  s_roce_bth_valid;
  logic                  s_roce_bth_ready;
  logic [7:0]            s_roce_bth_op_code;
  logic [23:0]           s_roce_bth_psn;
  logic [23:0]           s_roce_bth_dest_qp;
  logic                  s_roce_bth_ack_req;
  logic                  s_roce_reth_valid;
  logic                  s_roce_reth_ready;
  logic [63:0]           s_roce_reth_v_addr;
  logic [31:0]           s_roce_reth_length;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic [KEEP_WIDTH-1:0] s_axis_tkeep;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  logic                  s_axis_tuser;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [KEEP_WIDTH-1:0] m_axis_tkeep;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  m_axis_tuser;
  logic [63:0]           m_axis_addr;
  logic                  m_ack_valid;
  logic                  m_ack_ready;
  logic [23:0]           m_ack_psn;
  logic [7:0]            m_ack_syndrome;

  modport slave (
    input  s_roce_bth_valid, s_roce_bth_op_code, s_roce_bth_psn,
    input  s_roce_bth_dest_qp, s_roce_bth_ack_req,
    input  s_roce_reth_valid, s_roce_reth_v_addr, s_roce_reth_length,
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid,
    input  s_axis_tlast, s_axis_tuser,
    input  m_axis_tready, m_ack_ready,
    output s_roce_bth_ready, s_roce_reth_ready, s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
    output m_axis_tlast, m_axis_tuser, m_axis_addr,
    output m_ack_valid, m_ack_psn, m_ack_syndrome
  );

  modport master (
    output s_roce_bth_valid, s_roce_bth_op_code, s_roce_bth_psn,
    output s_roce_bth_dest_qp, s_roce_bth_ack_req,
    output s_roce_reth_valid, s_roce_reth_v_addr, s_roce_reth_length,
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid,
    output s_axis_tlast, s_axis_tuser,
    output m_axis_tready, m_ack_ready,
    input  s_roce_bth_ready, s_roce_reth_ready, s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
    input  m_axis_tlast, m_axis_tuser, m_axis_addr,
    input  m_ack_valid, m_ack_psn, m_ack_syndrome
  );
endinterface

// File: rtl/roce_rx_header_consumer.sv
// RoCEv2 RX header consumer: PSN/opcode checks, write-address tagging, ACK/NAK.
// Optional ROCE_RX_QP_FILTER_EN: silently drop packets for a foreign QP.
module roce_rx_header_consumer #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic        clk,
  input  logic        resetn,
  roce_rx_header_consumer_if.slave bus,
  input  logic [23:0] cfg_local_qp_i,
  output logic [31:0] stat_drop_count_o
);
  localparam int PCW = $clog2(KEEP_WIDTH) + 1;

  localparam logic [7:0] OP_FIRST    = 8'h06;
  localparam logic [7:0] OP_MIDDLE   = 8'h07;
  localparam logic [7:0] OP_LAST     = 8'h08;
  localparam logic [7:0] OP_LAST_IMM = 8'h09;
  localparam logic [7:0] OP_ONLY     = 8'h0A;
  localparam logic [7:0] OP_ONLY_IMM = 8'h0B;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RETH, S_PASS, S_DROP, S_ACK
  } state_t;

  state_t      state_q;
  logic        bth_ready_q;
  logic        reth_ready_q;
  logic        ack_valid_q;
  logic [7:0]  op_q;
  logic [23:0] psn_q;
  logic        ack_req_q;
  logic [23:0] epsn_q;
  logic        psn_sync_q;
  logic        in_msg_q;
  logic [63:0] addr_q;
  logic [31:0] remaining_q;
  logic        bad_q;
  logic        need_ack_q;
  logic [23:0] ack_psn_q;
  logic [7:0]  ack_syn_q;
  logic [31:0] drop_cnt_q;

`ifdef ROCE_RX_QP_FILTER_EN
  logic [23:0] dest_qp_q;
`else
  logic unused_qp;
  assign unused_qp = ^{cfg_local_qp_i, bus.s_roce_bth_dest_qp};
`endif

  logic is_first, is_mid, is_last, is_only;
  logic seq_err, psn_ok;
  logic [23:0] epsn_cur;
  logic [31:0] drop_inc;

  assign is_first = op_q == OP_FIRST;
  assign is_mid   = op_q == OP_MIDDLE;
  assign is_last  = op_q inside {OP_LAST, OP_LAST_IMM};
  assign is_only  = op_q inside {OP_ONLY, OP_ONLY_IMM};

  assign seq_err = ((is_first | is_only) & in_msg_q)
                 | ((is_mid | is_last) & ~in_msg_q)
                 | ~(is_first | is_mid | is_last | is_only);

  // Unsynced receiver adopts the packet PSN as the expected one.
  assign epsn_cur = psn_sync_q ? epsn_q : psn_q;
  assign psn_ok   = psn_q == epsn_cur;
  assign drop_inc = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + 32'd1;

  logic             pass, drop, beat;
  logic [PCW-1:0]   pc;
  logic [31:0]      pc32;
  logic             over;
  logic [31:0]      remaining_d;
  logic [63:0]      addr_d;
  logic             bad_d;

  assign pass = state_q == S_PASS;
  assign drop = state_q == S_DROP;
  assign beat = bus.s_axis_tvalid & bus.s_axis_tready;

  always_comb begin
    pc = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      pc = pc + PCW'(bus.s_axis_tkeep[i]);
  end

  assign pc32        = 32'(pc);
  assign over        = pc32 > remaining_q;
  assign remaining_d = over ? 32'd0 : remaining_q - pc32;
  assign addr_d      = addr_q + 64'(pc);
  assign bad_d       = bad_q | over | bus.s_axis_tuser
                     | (bus.s_axis_tlast & (is_last | is_only)
                        & (remaining_d != 32'd0));

  // Payload flows straight through while passing; no beat is buffered.
  assign bus.s_axis_tready = pass ? bus.m_axis_tready : drop;
  assign bus.m_axis_tvalid = pass & bus.s_axis_tvalid;
  assign bus.m_axis_tdata  = bus.s_axis_tdata;
  assign bus.m_axis_tkeep  = bus.s_axis_tkeep;
  assign bus.m_axis_tlast  = bus.s_axis_tlast;
  assign bus.m_axis_tuser  = bus.s_axis_tlast & bad_d;
  assign bus.m_axis_addr   = addr_q;

  assign bus.s_roce_bth_ready  = bth_ready_q;
  assign bus.s_roce_reth_ready = reth_ready_q;
  assign bus.m_ack_valid       = ack_valid_q;
  assign bus.m_ack_psn         = ack_psn_q;
  assign bus.m_ack_syndrome    = ack_syn_q;
  assign stat_drop_count_o     = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      bth_ready_q  <= 1'b0;
      reth_ready_q <= 1'b0;
      ack_valid_q  <= 1'b0;
      op_q         <= '0;
      psn_q        <= '0;
      ack_req_q    <= 1'b0;
      epsn_q       <= '0;
      psn_sync_q   <= 1'b0;
      in_msg_q     <= 1'b0;
      addr_q       <= '0;
      remaining_q  <= '0;
      bad_q        <= 1'b0;
      need_ack_q   <= 1'b0;
      ack_psn_q    <= '0;
      ack_syn_q    <= '0;
      drop_cnt_q   <= '0;
`ifdef ROCE_RX_QP_FILTER_EN
      dest_qp_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bth_ready_q && bus.s_roce_bth_valid) begin
            bth_ready_q <= 1'b0;
            op_q        <= bus.s_roce_bth_op_code;
            psn_q       <= bus.s_roce_bth_psn;
            ack_req_q   <= bus.s_roce_bth_ack_req;
`ifdef ROCE_RX_QP_FILTER_EN
            dest_qp_q   <= bus.s_roce_bth_dest_qp;
`endif
            state_q     <= S_CHECK;
          end else begin
            bth_ready_q <= 1'b1;
          end
        end
        S_CHECK: begin
          bad_q      <= 1'b0;
          need_ack_q <= 1'b0;
          state_q    <= S_DROP;
`ifdef ROCE_RX_QP_FILTER_EN
          if (dest_qp_q != cfg_local_qp_i) begin
            drop_cnt_q <= drop_inc;
          end else
`endif
          begin
            epsn_q     <= epsn_cur;
            psn_sync_q <= 1'b1;
            ack_psn_q  <= epsn_cur;
            need_ack_q <= 1'b1;
            if (!psn_ok) begin
              ack_syn_q  <= 8'h60;
              drop_cnt_q <= drop_inc;
            end else if (seq_err) begin
              ack_syn_q  <= 8'h61;
              in_msg_q   <= 1'b0;
              drop_cnt_q <= drop_inc;
            end else begin
              ack_psn_q  <= psn_q;
              ack_syn_q  <= 8'h00;
              need_ack_q <= ack_req_q;
              if (is_first || is_only) begin
                reth_ready_q <= 1'b1;
                state_q      <= S_RETH;
              end else begin
                state_q      <= S_PASS;
              end
            end
          end
        end
        S_RETH: begin
          if (reth_ready_q && bus.s_roce_reth_valid) begin
            reth_ready_q <= 1'b0;
            addr_q       <= bus.s_roce_reth_v_addr;
            remaining_q  <= bus.s_roce_reth_length;
            if (is_first) in_msg_q <= 1'b1;
            state_q      <= S_PASS;
          end
        end
        S_PASS: begin
          if (beat) begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            bad_q       <= bad_d;
            if (bus.s_axis_tlast) begin
              epsn_q <= epsn_q + 24'd1;
              if (is_last || is_only) in_msg_q <= 1'b0;
              if (need_ack_q) begin
                ack_valid_q <= 1'b1;
                state_q     <= S_ACK;
              end else begin
                bth_ready_q <= 1'b1;
                state_q     <= S_IDLE;
              end
            end
          end
        end
        S_DROP: begin
          if (beat && bus.s_axis_tlast) begin
            if (need_ack_q) begin
              ack_valid_q <= 1'b1;
              state_q     <= S_ACK;
            end else begin
              bth_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_ACK: begin
          if (ack_valid_q && bus.m_ack_ready) begin
            ack_valid_q <= 1'b0;
            bth_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
